// File: rtl/mbx_ombx_reader.sv
// Outbound mailbox reader: fetches a response object word by word from memory
// and presents each word to the system side until it is popped.
module mbx_ombx_reader #(
  parameter bit CfgOmbx = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mbx_read_i,
  input  logic        mbx_clear_i,
  input  logic [31:0] range_base_i,
  input  logic [31:0] range_limit_i,
  input  logic [10:0] object_size_i,
  input  logic        sys_read_pop_i,
  output logic        rd_req_o,
  output logic [31:0] rd_addr_o,
  input  logic        rd_gnt_i,
  input  logic        rd_rvalid_i,
  input  logic [31:0] rd_rdata_i,
  input  logic        rd_err_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        sys_read_all_o,
  output logic        read_error_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rd_ptr_q, rd_ptr_d;
  logic [10:0] remaining_q, remaining_d;
  logic        wrap_q, wrap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [32:0] ptr_inc;
  logic        range_err, abort;
  logic        req_c, all_c, err_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      wrap_q      <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      wrap_q      <= wrap_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    wrap_d      = wrap_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    req_c       = 1'b0;
    all_c       = 1'b0;
    err_c       = 1'b0;
    ptr_inc     = {1'b0, rd_ptr_q} + 33'd4;
    // A pointer that wrapped past 2^32 is out of range no matter the limit.
    range_err   = wrap_q || (rd_ptr_q > range_limit_i);
    // Dropping the read request mid-transfer is handled like an explicit clear.
    abort       = mbx_clear_i ||
                  (!mbx_read_i && (state_q == REQ || state_q == WAIT || state_q == HOLD));

    // The request stays visible during an abort so a same-cycle grant is seen.
    if (state_q == REQ) req_c = !range_err;

    if (abort) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      if (state_q == WAIT || (state_q == REQ && req_c && rd_gnt_i)) state_d = DRAIN;
      else                                                          state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mbx_read_i) begin
            if (object_size_i == '0) begin
              all_c   = 1'b1;
              state_d = DONE;
            end else begin
              rd_ptr_d    = range_base_i;
              remaining_d = object_size_i;
              wrap_d      = 1'b0;
              state_d     = REQ;
            end
          end
        end
        REQ: begin
          if (range_err) begin
            err_c   = 1'b1;
            state_d = IDLE;
          end else if (rd_gnt_i) begin
            rd_ptr_d = ptr_inc[31:0];
            wrap_d   = ptr_inc[32];
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (rd_rvalid_i) begin
            if (rd_err_i) begin
              err_c   = 1'b1;
              state_d = IDLE;
            end else begin
              rdata_d  = rd_rdata_i;
              rvalid_d = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (sys_read_pop_i && rvalid_q) begin
            rvalid_d    = 1'b0;
            remaining_d = remaining_q - 11'd1;
            if (remaining_q == 11'd1) begin
              all_c   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = REQ;
            end
          end
        end
        DONE:  if (!mbx_read_i) state_d = IDLE;
        DRAIN: if (rd_rvalid_i) state_d = IDLE;
        default: begin
          err_c   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    if (!CfgOmbx) begin
      state_d     = IDLE;
      rd_ptr_d    = '0;
      remaining_d = '0;
      wrap_d      = 1'b0;
      rdata_d     = '0;
      rvalid_d    = 1'b0;
      req_c       = 1'b0;
      all_c       = 1'b0;
      err_c       = 1'b0;
    end
  end

  // Request is decoded from the state register so reset removes it at once.
  assign rd_req_o       = req_c;
  assign rd_addr_o      = rd_ptr_q;
  assign rdata_o        = rdata_q;
  assign rdata_valid_o  = rvalid_q;
  assign sys_read_all_o = all_c;
  assign read_error_o   = err_c;

endmodule

// File: tb/tb_mbx_ombx_reader.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared every cycle against an object-level model of the reader.
module tb_mbx_ombx_reader;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        mbx_read_i, mbx_clear_i, sys_read_pop_i;
  logic [31:0] range_base_i, range_limit_i;
  logic [10:0] object_size_i;
  logic        rd_gnt_i, rd_rvalid_i, rd_err_i;
  logic [31:0] rd_rdata_i;
  logic        rd_req_o, rdata_valid_o, sys_read_all_o, read_error_o;
  logic [31:0] rd_addr_o, rdata_o;
  logic        d_req, d_valid, d_all, d_err;
  logic [31:0] d_addr, d_rdata;

  always #5 clk = ~clk;

  mbx_ombx_reader u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .mbx_read_i(mbx_read_i), .mbx_clear_i(mbx_clear_i),
    .range_base_i(range_base_i), .range_limit_i(range_limit_i), .object_size_i(object_size_i),
    .sys_read_pop_i(sys_read_pop_i), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
    .rd_gnt_i(rd_gnt_i), .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i), .rd_err_i(rd_err_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .sys_read_all_o(sys_read_all_o),
    .read_error_o(read_error_o)
  );

  mbx_ombx_reader #(.CfgOmbx(1'b0)) u_dis (
    .clk_i(clk), .rst_ni(rst_ni), .mbx_read_i(mbx_read_i), .mbx_clear_i(mbx_clear_i),
    .range_base_i(range_base_i), .range_limit_i(range_limit_i), .object_size_i(object_size_i),
    .sys_read_pop_i(sys_read_pop_i), .rd_req_o(d_req), .rd_addr_o(d_addr),
    .rd_gnt_i(rd_gnt_i), .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i), .rd_err_i(rd_err_i),
    .rdata_o(d_rdata), .rdata_valid_o(d_valid), .sys_read_all_o(d_all), .read_error_o(d_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- object-level reference model ----------------
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3, P_DONE = 4, P_DRAIN = 5;
  int          m_phase, m_total, m_idx;
  logic [31:0] m_base, m_word;
  bit          m_have;

  // Word k of the object lives at base + 4k; anything past the limit or 2^32 is out of range.
  function automatic logic [32:0] m_addr();
    return {1'b0, m_base} + (33'(m_idx) << 2);
  endfunction
  function automatic bit m_rerr();
    return m_addr() > {1'b0, range_limit_i};
  endfunction
  function automatic bit m_abort();
    return mbx_clear_i || (!mbx_read_i && (m_phase == P_REQ || m_phase == P_WAIT || m_phase == P_HOLD));
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase <= P_IDLE; m_total <= 0; m_idx <= 0; m_base <= '0; m_word <= '0; m_have <= 1'b0;
    end else if (m_abort()) begin
      m_phase <= (m_phase == P_WAIT || (m_phase == P_REQ && !m_rerr() && rd_gnt_i)) ? P_DRAIN : P_IDLE;
      m_have  <= 1'b0;
      m_word  <= '0;
    end else begin
      case (m_phase)
        P_IDLE: if (mbx_read_i) begin
          if (object_size_i == 0) m_phase <= P_DONE;
          else begin
            m_base <= range_base_i; m_total <= int'(object_size_i); m_idx <= 0; m_phase <= P_REQ;
          end
        end
        P_REQ:  if (m_rerr()) m_phase <= P_IDLE; else if (rd_gnt_i) m_phase <= P_WAIT;
        P_WAIT: if (rd_rvalid_i) begin
          if (rd_err_i) m_phase <= P_IDLE;
          else begin m_word <= rd_rdata_i; m_have <= 1'b1; m_phase <= P_HOLD; end
        end
        P_HOLD: if (sys_read_pop_i && m_have) begin
          m_have  <= 1'b0;
          m_idx   <= m_idx + 1;
          m_phase <= (m_idx + 1 == m_total) ? P_DONE : P_REQ;
        end
        P_DONE:  if (!mbx_read_i) m_phase <= P_IDLE;
        default: if (rd_rvalid_i) m_phase <= P_IDLE;
      endcase
    end
  end

  // ---------------- memory model ----------------
  logic        req_seen = 1'b0, mem_pend;
  logic [31:0] addr_seen = '0, mem_addr;
  int          mem_cnt, mem_delay = 0;
  bit          mem_err_force = 0, rand_err = 0, stray_en = 0;
  logic [31:0] acc_q[$];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_pend <= 1'b0; mem_cnt <= 0; mem_addr <= '0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 0) mem_pend <= 1'b0; else mem_cnt <= mem_cnt - 1;
      end
      if (req_seen && rd_gnt_i) begin
        mem_pend <= 1'b1;
        mem_cnt  <= (mem_delay < 0) ? int'($urandom_range(3)) : mem_delay;
        mem_addr <= addr_seen;
        acc_q.push_back(addr_seen);
      end
    end
  end

  task automatic drive_mem();
    rd_rvalid_i = mem_pend && mem_cnt == 0;
    rd_rdata_i  = rd_rvalid_i ? (mem_addr ^ 32'h5A5A_0000) : $urandom;
    rd_err_i    = rd_rvalid_i ? (mem_err_force || (rand_err && $urandom_range(9) == 0))
                              : 1'($urandom_range(1));
    if (stray_en && !rd_rvalid_i && (m_phase == P_IDLE || m_phase == P_DONE) &&
        $urandom_range(29) == 0) begin
      rd_rvalid_i = 1'b1;
      rd_err_i    = 1'($urandom_range(1));
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    drive_mem();
  endtask

  // ---------------- per-cycle compare and monitor ----------------
  int          all_cnt, err_cnt, req_cyc, vld_cyc, err_with_req, all_pops;
  logic [31:0] pop_q[$];

  task automatic clr_stats();
    all_cnt = 0; err_cnt = 0; req_cyc = 0; vld_cyc = 0; err_with_req = 0; all_pops = 0;
    pop_q.delete(); acc_q.delete();
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial forever begin
    bit e_req, e_all, e_err, ab;
    logic [32:0] a;
    @(negedge clk);
    req_seen  = rd_req_o;
    addr_seen = rd_addr_o;
    if (!rst_ni) begin
      e_req = 0; e_all = 0; e_err = 0;
      chk("rdata_valid", rdata_valid_o, 0);
      chk("rdata", rdata_o, 0);
    end else begin
      ab    = m_abort();
      a     = m_addr();
      e_req = m_phase == P_REQ && !m_rerr();
      e_all = !ab && ((m_phase == P_IDLE && mbx_read_i && object_size_i == 0) ||
                      (m_phase == P_HOLD && sys_read_pop_i && m_have && m_total - m_idx == 1));
      e_err = !ab && ((m_phase == P_REQ && m_rerr()) ||
                      (m_phase == P_WAIT && rd_rvalid_i && rd_err_i));
      chk("rdata_valid", rdata_valid_o, m_have);
      chk("rdata", rdata_o, m_word);
      if (e_req) chk("rd_addr", rd_addr_o, a[31:0]);
    end
    chk("rd_req", rd_req_o, e_req);
    chk("sys_read_all", sys_read_all_o, e_all);
    chk("read_error", read_error_o, e_err);
    chk("cfg0 outputs", d_rdata | d_addr | {28'd0, d_req, d_valid, d_all, d_err}, 0);
    if (rdata_valid_o && sys_read_pop_i) pop_q.push_back(rdata_o);
    if (sys_read_all_o) begin all_cnt++; all_pops = pop_q.size(); end
    if (read_error_o) begin err_cnt++; if (rd_req_o) err_with_req++; end
    if (rd_req_o) req_cyc++;
    if (rdata_valid_o) vld_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_ni = 1'b0; mbx_read_i = 0; mbx_clear_i = 0; sys_read_pop_i = 0; rd_gnt_i = 0;
    repeat (2) cyc();
    rst_ni = 1'b1;
  endtask

  task automatic new_obj();
    if ($urandom_range(7) == 0) begin
      range_base_i  = 32'hFFFF_FFF8;
      range_limit_i = 32'hFFFF_FFFF;
      object_size_i = 11'($urandom_range(4, 1));
    end else begin
      range_base_i  = 32'($urandom_range(255)) << 12;
      range_limit_i = range_base_i + 32'($urandom_range(6)) * 4;
      if ($urandom_range(9) == 0) range_limit_i = range_base_i - 32'd4;
      object_size_i = 11'($urandom_range(6));
    end
  endtask

  task automatic rand_drive();
    if (mbx_read_i) begin
      if (m_phase == P_DONE ? $urandom_range(2) == 0 : $urandom_range(79) == 0) mbx_read_i = 0;
    end else if ($urandom_range(3) == 0) begin
      new_obj();
      mbx_read_i = 1;
    end
    mbx_clear_i    = $urandom_range(99) == 0;
    rd_gnt_i       = $urandom_range(2) == 0;
    sys_read_pop_i = 1'($urandom_range(1));
  endtask

  initial begin
    bit hit;
    rst_ni = 0; mbx_read_i = 0; mbx_clear_i = 0; sys_read_pop_i = 0; rd_gnt_i = 0;
    range_base_i = 0; range_limit_i = 0; object_size_i = 0;
    rd_rvalid_i = 0; rd_rdata_i = 0; rd_err_i = 0;
    repeat (3) cyc();
    chk("reset rd_req", rd_req_o, 0);
    chk("reset rd_addr", rd_addr_o, 0);
    chk("reset rdata_valid", rdata_valid_o, 0);
    chk("reset rdata", rdata_o, 0);
    rst_ni = 1;

    // three-word object, zero-wait memory, every word popped
    do_reset(); clr_stats();
    range_base_i = 32'h1000; range_limit_i = 32'h100C; object_size_i = 3;
    rd_gnt_i = 1; sys_read_pop_i = 1; mem_delay = 0; mbx_read_i = 1;
    repeat (20) cyc();
    chk("t045 grants", acc_q.size(), 3);
    chk("t045 addr0", qget(acc_q, 0), 32'h1000);
    chk("t045 addr1", qget(acc_q, 1), 32'h1004);
    chk("t045 addr2", qget(acc_q, 2), 32'h1008);
    chk("t045 word2", qget(pop_q, 2), 32'h5A5A_1008);
    chk("t045 all pulses", all_cnt, 1);
    chk("t045 pops at all", all_pops, 3);
    chk("t045 idle in done", rd_req_o, 0);
    mbx_read_i = 0; cyc();

    // empty object
    do_reset(); clr_stats();
    object_size_i = 0; cyc();
    mbx_read_i = 1; #1;
    chk("t046 all same cycle", sys_read_all_o, 1);
    repeat (5) cyc();
    chk("t046 no req", req_cyc, 0);
    chk("t046 all pulses", all_cnt, 1);
    mbx_read_i = 0; cyc();

    // limit cuts object short
    do_reset(); clr_stats();
    range_base_i = 32'h1000; range_limit_i = 32'h1004; object_size_i = 4;
    rd_gnt_i = 1; sys_read_pop_i = 1; mbx_read_i = 1;
    for (int i = 0; i < 40 && err_cnt == 0; i++) cyc();
    mbx_read_i = 0;
    repeat (3) cyc();
    chk("t047 errors", err_cnt, 1);
    chk("t047 words", pop_q.size(), 2);
    chk("t047 grants", acc_q.size(), 2);
    chk("t047 req at error", err_with_req, 0);

    // clear while waiting, erroring response lands in DRAIN
    do_reset(); clr_stats();
    range_base_i = 32'h2000; range_limit_i = 32'h2FFC; object_size_i = 2;
    rd_gnt_i = 1; sys_read_pop_i = 1; mem_delay = 3; mem_err_force = 1; mbx_read_i = 1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cyc(); hit = acc_q.size() == 1; end
    chk("t048 granted", acc_q.size(), 1);
    mbx_clear_i = 1; mbx_read_i = 0;
    cyc(); mbx_clear_i = 0; mbx_read_i = 1; #1;
    chk("t048 drain no req a", rd_req_o, 0);
    cyc(); #1;
    chk("t048 drain no req b", rd_req_o, 0);
    cyc(); #1;
    chk("t048 rvalid err no error", read_error_o, 0);
    chk("t048 no valid", rdata_valid_o, 0);
    cyc(); mem_err_force = 0; #1;
    chk("t048 idle no req", rd_req_o, 0);
    cyc(); #1;
    chk("t048 restart req", rd_req_o, 1);
    chk("t048 restart addr", rd_addr_o, 32'h2000);
    mbx_read_i = 0;
    repeat (6) cyc();
    chk("t048 errors", err_cnt, 0);
    chk("t048 valid cycles", vld_cyc, 0);

    // grant held off five cycles
    do_reset(); clr_stats();
    range_base_i = 32'h1000; range_limit_i = 32'h1FFC; object_size_i = 1;
    rd_gnt_i = 0; sys_read_pop_i = 1; mem_delay = 0; mbx_read_i = 1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      rd_gnt_i = (i == 5); #1;
      chk("t049 req held", rd_req_o, 1);
      chk("t049 addr stable", rd_addr_o, 32'h1000);
      cyc();
    end
    rd_gnt_i = 0; #1;
    chk("t049 one grant", acc_q.size(), 1);
    chk("t049 req dropped", rd_req_o, 0);
    repeat (4) cyc();
    chk("t049 all", all_cnt, 1);
    mbx_read_i = 0; cyc();

    // reset while a word is held
    do_reset(); clr_stats();
    range_base_i = 32'h1000; range_limit_i = 32'h1FFC; object_size_i = 2;
    rd_gnt_i = 1; sys_read_pop_i = 0; mbx_read_i = 1;
    repeat (4) cyc();
    chk("t050 valid before", rdata_valid_o, 1);
    chk("t050 word before", rdata_o, 32'h5A5A_1000);
    #2 rst_ni = 0; #1;
    chk("t050 async outs", {rdata_o, 28'd0, rd_req_o, rdata_valid_o, sys_read_all_o, read_error_o}, 0);
    chk("t050 async addr", rd_addr_o, 0);
    repeat (2) cyc();
    range_base_i = 32'h3000; range_limit_i = 32'h3FFC; rst_ni = 1;
    cyc(); #1;
    chk("t050 restart req", rd_req_o, 1);
    chk("t050 restart addr", rd_addr_o, 32'h3000);
    mbx_read_i = 0; repeat (4) cyc();

    // randomized traffic
    do_reset(); clr_stats();
    mem_delay = -1; rand_err = 1; stray_en = 1;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rand_drive();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mbx_ombx_reader.md
MBX_OMBX_READER -- requirements
Module: mbx_ombx_reader

Interface
REQ-001 Parameter: CfgOmbx, 1'b1, enables the block; when 0, all outputs SHALL be held at reset values.
REQ-002 clk_i  input  1  clock; all state SHALL be updated on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 mbx_read_i  input  1  mailbox FSM is in the read state.
REQ-005 mbx_clear_i  input  1  abort, error or abort-ack clear request; single-cycle pulse.
REQ-006 range_base_i  input  32  first word byte address, 4-byte aligned.
REQ-007 range_limit_i  input  32  last valid word byte address, inclusive.
REQ-008 object_size_i  input  11  response object length in 32-bit words.
REQ-009 sys_read_pop_i  input  1  system side consumed rdata_o.
REQ-010 rd_req_o  output  1  memory read request.
REQ-011 rd_addr_o  output  32  memory read byte address.
REQ-012 rd_gnt_i  input  1  memory accepted the request.
REQ-013 rd_rvalid_i  input  1  read response valid.
REQ-014 rd_rdata_i  input  32  read response data.
REQ-015 rd_err_i  input  1  read response error; qualified by rd_rvalid_i.
REQ-016 rdata_o  output  32  word presented to the system side.
REQ-017 rdata_valid_o  output  1  rdata_o holds an unconsumed word.
REQ-018 sys_read_all_o  output  1  one-cycle pulse when the last word is consumed.
REQ-019 read_error_o  output  1  one-cycle pulse on a range or memory error.

Function
REQ-020 States: IDLE, REQ, WAIT, HOLD, DONE, DRAIN.
REQ-021 Internal registers: 32-bit rd_ptr and 11-bit remaining.
REQ-022 IDLE -> REQ when mbx_read_i=1 and object_size_i!=0; load rd_ptr=range_base_i and remaining=object_size_i.
REQ-023 IDLE, when mbx_read_i=1 and object_size_i=0: pulse sys_read_all_o in that cycle and go to DONE.
REQ-024 REQ: drive rd_req_o=1 and rd_addr_o=rd_ptr; hold both stable until rd_gnt_i.
REQ-025 REQ: if rd_ptr > range_limit_i on entry, do not assert rd_req_o; pulse read_error_o and go to IDLE.
REQ-026 REQ with rd_gnt_i=1: go to WAIT and set rd_ptr += 4; the add wraps modulo 2^32, and a wrap SHALL flag a range error at the next REQ.
REQ-027 At most one memory request SHALL be outstanding.
REQ-028 WAIT with rd_rvalid_i=1 and rd_err_i=0: register rd_rdata_i into rdata_o, set rdata_valid_o the next cycle, and go to HOLD.
REQ-029 WAIT with rd_rvalid_i=1 and rd_err_i=1: pulse read_error_o, leave rdata_valid_o=0, and go to IDLE.
REQ-030 HOLD with sys_read_pop_i=1: clear rdata_valid_o and decrement remaining.
REQ-031 HOLD pop when remaining=1: pulse sys_read_all_o in the same cycle and go to DONE; otherwise go to REQ.
REQ-032 sys_read_pop_i SHALL be ignored whenever rdata_valid_o=0.
REQ-033 Read latency: a new word is valid no earlier than 2 cycles after rd_gnt_i.
REQ-034 DONE -> IDLE when mbx_read_i=0.
REQ-035 mbx_clear_i has priority over every other event.
REQ-036 mbx_clear_i in WAIT, or in REQ with rd_gnt_i=1 in the same cycle: go to DRAIN.
REQ-037 mbx_clear_i in any other state: go to IDLE.
REQ-038 On mbx_clear_i in all cases: rdata_valid_o=0, rdata_o=0, no sys_read_all_o pulse.
REQ-039 DRAIN: discard the response and go to IDLE on rd_rvalid_i, with no read_error_o even if rd_err_i=1.
REQ-040 mbx_read_i falling in REQ, WAIT or HOLD SHALL be treated as mbx_clear_i.
REQ-041 Illegal state encoding: go to IDLE and pulse read_error_o.

Reset
REQ-042 During reset: state=IDLE, rd_ptr=0, remaining=0, rdata_o=0, and all single-bit outputs=0.
REQ-043 rd_req_o SHALL deassert asynchronously with reset.
REQ-044 A response arriving after reset release SHALL be ignored in IDLE.

Verification
REQ-045 base=0x1000, limit=0x100C, size=3, zero-wait memory, pop each word -> addresses 0x1000/0x1004/0x1008; sys_read_all_o pulses on the third pop; state DONE.
REQ-046 size=0 with mbx_read_i rising -> sys_read_all_o pulses in that cycle; rd_req_o never asserts.
REQ-047 base=0x1000, limit=0x1004, size=4 -> two words delivered; third REQ pulses read_error_o with no rd_req_o.
REQ-048 mbx_clear_i in WAIT, then rd_rvalid_i 3 cycles later with rd_err_i=1 -> DRAIN absorbs the response; no read_error_o and no rdata_valid_o; IDLE.
REQ-049 rd_gnt_i delayed 5 cycles -> rd_addr_o is stable for 6 cycles; exactly one grant.
REQ-050 rst_ni asserted while rdata_valid_o=1 -> all outputs 0 immediately; after release, new mbx_read_i restarts from range_base_i.
